// File: rtl/alu_arbiter.sv
// Two-requester arbiter that shares one combinational ALU, returning each result on a
// registered response channel and counting genuine overflow events.
module alu_arbiter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [31:0]      r0_instr,
   input  logic [31:0]      r0_a,
   input  logic [31:0]      r0_b,
   input  logic [9:0]       r0_pc,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [31:0]      r1_instr,
   input  logic [31:0]      r1_a,
   input  logic [31:0]      r1_b,
   input  logic [9:0]       r1_pc,
   output logic [31:0]      alu_i,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [9:0]       alu_pc,
   input  logic [31:0]      alu_o,
   input  logic             alu_zero,
   input  logic             alu_flow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [31:0]      rsp_data,
   output logic             rsp_zero,
   output logic             rsp_flow,
   output logic [CNT_W-1:0] ovf_count,
   output logic             busy
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StExec = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = 1;

   logic [1:0]       state_q, state_d;
   logic             last_q, last_d;
   logic             id_q, id_d;
   logic [31:0]      op_instr_q, op_instr_d;
   logic [31:0]      op_a_q, op_a_d;
   logic [31:0]      op_b_q, op_b_d;
   logic [9:0]       op_pc_q, op_pc_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic             rsp_id_q, rsp_id_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_flow_q, rsp_flow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic gnt_id;
   logic accept;
   logic flow_ok;
   logic flow_masked;

   // On a conflict the requester that did not win last time gets the grant.
   always_comb begin
      gnt_id = (r0_valid && r1_valid) ? ~last_q : r1_valid;
   end

   assign r0_ready = (state_q == StIdle) && r0_valid && !gnt_id;
   assign r1_ready = (state_q == StIdle) && r1_valid && gnt_id;
   assign accept   = r0_ready || r1_ready;

   // The ALU leaves a stale flow value for ops that do not compute it.
   always_comb begin
      flow_ok = 1'b0;
      case (op_instr_q[6:0])
         7'b0110011: flow_ok = (op_instr_q[14:12] == 3'b000) &&
                               ((op_instr_q[31:25] == 7'b0000000) ||
                                (op_instr_q[31:25] == 7'b0100000));
         7'b0010011: flow_ok = (op_instr_q[14:12] == 3'b000);
         7'b0100011: flow_ok = 1'b1;
         7'b1100111: flow_ok = 1'b1;
         7'b1101111: flow_ok = 1'b1;
         default:    flow_ok = 1'b0;
      endcase
      flow_masked = flow_ok && alu_flow;
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      id_d       = id_q;
      op_instr_d = op_instr_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_pc_d    = op_pc_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      rsp_zero_d = rsp_zero_q;
      rsp_flow_d = rsp_flow_q;
      cnt_d      = cnt_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               op_instr_d = gnt_id ? r1_instr : r0_instr;
               op_a_d     = gnt_id ? r1_a : r0_a;
               op_b_d     = gnt_id ? r1_b : r0_b;
               op_pc_d    = gnt_id ? r1_pc : r0_pc;
               id_d       = gnt_id;
               last_d     = gnt_id;
               state_d    = StExec;
            end
         end
         StExec: begin
            rsp_data_d = alu_o;
            rsp_zero_d = alu_zero;
            rsp_flow_d = flow_masked;
            rsp_id_d   = id_q;
            if (flow_masked && (cnt_q != CntMax)) begin
               cnt_d = cnt_q + CntOne;
            end
            state_d = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         last_q     <= 1'b1;
         id_q       <= 1'b0;
         op_instr_q <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_pc_q    <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= 1'b0;
         rsp_zero_q <= 1'b0;
         rsp_flow_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         id_q       <= id_d;
         op_instr_q <= op_instr_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_pc_q    <= op_pc_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         rsp_zero_q <= rsp_zero_d;
         rsp_flow_q <= rsp_flow_d;
         cnt_q      <= cnt_d;
      end
   end

   assign alu_i     = op_instr_q;
   assign alu_a     = op_a_q;
   assign alu_b     = op_b_q;
   assign alu_pc    = op_pc_q;
   assign rsp_valid = (state_q == StResp);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_zero  = rsp_zero_q;
   assign rsp_flow  = rsp_flow_q;
   assign ovf_count = cnt_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer that shares the single combinational ALU between the main execute pipeline (requester 0) and a secondary unit such as the address/debug path (requester 1). It accepts one operation at a time through a valid/ready handshake and latches its operands onto the ALU inputs. It captures the ALU result and returns it on a registered response channel tagged with the requester id. It also keeps a saturating count of genuine overflow events.

## Interface
Parameters:
- CNT_W, 8, width of the overflow event counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- r0_valid / r1_valid  in  1  request valid, requester 0 / 1
- r0_ready / r1_ready  out  1  request accepted this cycle when high with valid
- r0_instr / r1_instr  in  32  instruction word (RISC-V layout, opcode [6:0])
- r0_a, r0_b / r1_a, r1_b  in  32  rs1 / rs2 operand values
- r0_pc / r1_pc  in  10  PC of the instruction
- alu_i  out  32  instruction to ALU
- alu_a, alu_b  out  32  operands to ALU
- alu_pc  out  10  PC to ALU
- alu_o  in  32  ALU result
- alu_zero, alu_flow  in  1  ALU zero and overflow flags
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that issued the response (0/1)
- rsp_data  out  32  captured result
- rsp_zero, rsp_flow  out  1  captured zero flag, masked overflow flag
- ovf_count  out  CNT_W  saturating count of masked overflow events
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: compute the grant. With one valid, grant that requester. With both valid, grant the requester other than `last`. `last` resets to 1, so r0 wins the first conflict. Only the granted requester sees ready=1, and only in IDLE. On valid&ready: latch instr/a/b/pc into the operand register, latch id, set `last`=id, go to EXEC.
- EXEC: alu_i/a/b/pc are driven from the operand register. At the end of the cycle, capture alu_o→rsp_data, alu_zero→rsp_zero, masked flow→rsp_flow, id→rsp_id. Go to RESP.
- alu_* outputs always reflect the operand register, never the raw request ports. This keeps them stable outside EXEC.
- Flow mask: the ALU holds a stale flow value for ops that do not compute it. rsp_flow = alu_flow only for the following latched instructions, and 0 for all others:
  - opcode 0110011 with {funct7,funct3} = add (0000000,000) or sub (0100000,000)
  - opcode 0010011 with funct3 000
  - opcode 0100011
  - opcode 1100111 or 1101111
- ovf_count increments by 1 on EXEC capture when masked flow = 1. It saturates at 2^CNT_W−1 and never wraps.
- RESP: rsp_valid=1. rsp_id/data/zero/flow are held stable until rsp_valid&rsp_ready. On that handshake go to IDLE. No request is accepted in the handshake cycle.
- An unselected requester holding valid keeps waiting. Its request is not dropped and is not required to be stable until accepted.

## Timing
- Reset (rst_n=0 at clk edge), applied in any state:
  - state IDLE, `last`=1
  - operand register, rsp_data, rsp_id, rsp_zero, rsp_flow, ovf_count all 0
  - rsp_valid=0, busy=0
  - r0_ready/r1_ready come from the IDLE grant logic, so they are 0 unless a valid is present
  - an in-flight operation is discarded without a response
- Accept at edge N → EXEC during cycle N+1 → rsp_valid high from cycle N+2.
- Minimum spacing between accepts is 3 cycles when rsp_ready is tied high.
- ready is combinational from the valids, `last` and state. valid must not depend on ready.
- Back-pressure: rsp_ready low holds RESP indefinitely. ready stays 0 for both requesters meanwhile.

## Test plan
- r0 only, instr 0x003100B3 (add), a=5, b=7, pc=0x010, rsp_ready=1. Required: r0_ready=1 at cycle 0, rsp_valid at cycle 2, rsp_data=12, rsp_id=0, rsp_zero=0, rsp_flow=0, busy high in cycles 1–2.
- r0 and r1 both continuously valid with the same add. Required: grants alternate 0,1,0,1,… starting with r0, each accept 3 cycles apart, the non-granted ready is always 0.
- add a=0x7FFFFFFF, b=1. Required: rsp_data=0x80000000, rsp_flow=1, ovf_count=1. Then sub 0x403100B3 with a=b=9. Required: rsp_data=0, rsp_zero=1, rsp_flow=0, ovf_count stays 1.
- After an overflowing add, issue and 0x003170B3 with the ALU model still driving alu_flow=1. Required: rsp_flow=0, ovf_count unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP. Required: rsp_* stable, both ready=0. On the rsp_ready=1 edge, the state is IDLE the next cycle and a pending r1 is accepted that cycle.
- Issue 256 overflowing adds. Required: ovf_count reaches 255 and stays 255. Then drive rst_n=0 during EXEC. Required: next cycle IDLE, rsp_valid=0, ovf_count=0, first conflict granted to r0.
